// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// LS has fixed priority; a saturating starvation counter forces an IF grant.
//
// state   | meaning
// IDLE    | no request outstanding
// BUSY_IF | request register holds a fetch
// BUSY_LS | request register holds a load/store
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_starve;
  logic                r_squash;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_ls_rvalid;
  logic [DATA_W-1:0]   r_ls_rdata;

  logic w_busy;
  logic w_arb;
  logic w_starved;
  logic w_gnt_ls;
  logic w_gnt_if;
  logic w_if_done;
  logic w_ls_done;
  logic w_flush_if;
  logic w_if_drop;

  assign w_busy     = (r_state != IDLE);
  assign w_arb      = ~w_busy | mem_ready_i;
  assign w_starved  = if_req_i & (r_starve == CNT_W'(STARVE_MAX));
  assign w_gnt_ls   = w_arb & ls_req_i & ~w_starved;
  assign w_gnt_if   = w_arb & if_req_i & ~w_gnt_ls;
  assign w_if_done  = (r_state == BUSY_IF) & mem_ready_i;
  assign w_ls_done  = (r_state == BUSY_LS) & mem_ready_i;
  assign w_flush_if = (r_state == BUSY_IF) & if_flush_i;
  // A flush arriving in the completion cycle itself still kills that response.
  assign w_if_drop  = r_squash | w_flush_if;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_squash    <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_if_done & ~w_if_drop;
      r_ls_rvalid <= w_ls_done;
      if (w_if_done && !w_if_drop) r_if_rdata <= mem_rdata_i;
      if (w_ls_done && !r_we)      r_ls_rdata <= mem_rdata_i;

      if (w_gnt_if && if_flush_i) r_squash <= 1'b1;
      else if (w_if_done)         r_squash <= 1'b0;
      else if (w_flush_if)        r_squash <= 1'b1;

      if (w_arb) begin
        if (!if_req_i || w_gnt_if)                 r_starve <= '0;
        else if (r_starve != CNT_W'(STARVE_MAX))   r_starve <= r_starve + CNT_W'(1);

        if (w_gnt_ls) begin
          r_state <= BUSY_LS;
          r_we    <= ls_we_i;
          r_be    <= ls_be_i;
          r_addr  <= ls_addr_i;
          r_wdata <= ls_wdata_i;
        end else if (w_gnt_if) begin
          r_state <= BUSY_IF;
          r_we    <= 1'b0;
          r_be    <= '1;
          r_addr  <= if_addr_i;
          r_wdata <= '0;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  // Grants are combinational; gating with reset keeps them low while reset is held.
  assign if_gnt_o    = w_gnt_if & rst_n_i;
  assign ls_gnt_o    = w_gnt_ls & rst_n_i;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rvalid_o = r_ls_rvalid;
  assign ls_rdata_o  = r_ls_rdata;
  assign mem_req_o   = w_busy;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, SMAX = 4;

  logic          clk_i = 1'b0, rst_n_i = 1'b0;
  logic          if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [BW-1:0] ls_be_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i, ls_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ready_i, busy_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_err = 0, n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0;
  endtask

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[4];

  // reference model state
  int          m_own;   // 0 none, 1 fetch, 2 load/store
  bit          m_we, m_kill, m_if_rv, m_ls_rv;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_ls_rd;
  int          m_starve;

  initial begin
    bit starve_pat[10];
    bit arb, e_if, e_ls, g_if, g_ls, nx_if_rv, nx_ls_rv;

    idle_inputs();
    tbl[0] = '{is_ls:0, we:0, be:4'hF, addr:32'h100,  wdata:32'h0,        rdata:32'h00A00093,
               waits:0, exp_we:0, exp_be:4'hF, exp_rdata:32'h00A00093};
    tbl[1] = '{is_ls:1, we:0, be:4'hF, addr:32'h2000, wdata:32'h0,        rdata:32'h11223344,
               waits:3, exp_we:0, exp_be:4'hF, exp_rdata:32'h11223344};
    tbl[2] = '{is_ls:1, we:1, be:4'h3, addr:32'h2004, wdata:32'hDEADBEEF, rdata:32'h55555555,
               waits:1, exp_we:1, exp_be:4'h3, exp_rdata:32'h11223344};
    tbl[3] = '{is_ls:0, we:0, be:4'hF, addr:32'h104,  wdata:32'h0,        rdata:32'hCAFEF00D,
               waits:2, exp_we:0, exp_be:4'hF, exp_rdata:32'hCAFEF00D};

    // reset state
    #1;
    chk("rst_outputs", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, busy_o, mem_we_o}, 0);
    chk("rst_rdata", {if_rdata_o, ls_rdata_o}, 0);
    @(negedge clk_i); rst_n_i = 1;
    @(negedge clk_i); #1;
    chk("idle_after_rst", {if_gnt_o, ls_gnt_o, mem_req_o, busy_o}, 0);

    // single transactions from IDLE
    for (int v = 0; v < 4; v++) begin
      @(negedge clk_i);
      if (tbl[v].is_ls) begin
        ls_req_i = 1; ls_we_i = tbl[v].we; ls_be_i = tbl[v].be;
        ls_addr_i = tbl[v].addr; ls_wdata_i = tbl[v].wdata;
      end else begin
        if_req_i = 1; if_addr_i = tbl[v].addr;
      end
      #1;
      chk($sformatf("tbl%0d_gnt", v), {if_gnt_o, ls_gnt_o}, tbl[v].is_ls ? 2'b01 : 2'b10);
      for (int c = 0; c <= tbl[v].waits; c++) begin
        @(negedge clk_i);
        if_req_i = 0; ls_req_i = 0;
        if_addr_i = 32'hFFFFFFF0; ls_addr_i = 32'hFFFFFFF0; ls_wdata_i = 32'h0; ls_be_i = 4'h0;
        mem_ready_i = (c == tbl[v].waits);
        mem_rdata_i = (c == tbl[v].waits) ? tbl[v].rdata : 32'h77777777;
        #1;
        chk($sformatf("tbl%0d_memreq_c%0d", v, c), {mem_req_o, busy_o}, 2'b11);
        chk($sformatf("tbl%0d_addr_c%0d", v, c), mem_addr_o, tbl[v].addr);
        chk($sformatf("tbl%0d_webe_c%0d", v, c), {mem_we_o, mem_be_o}, {tbl[v].exp_we, tbl[v].exp_be});
        if (tbl[v].exp_we) chk($sformatf("tbl%0d_wdata", v), mem_wdata_o, tbl[v].wdata);
        chk($sformatf("tbl%0d_norv_c%0d", v, c), {if_rvalid_o, ls_rvalid_o}, 0);
      end
      @(negedge clk_i); mem_ready_i = 0; #1;
      chk($sformatf("tbl%0d_rvalid", v), {if_rvalid_o, ls_rvalid_o}, tbl[v].is_ls ? 2'b01 : 2'b10);
      chk($sformatf("tbl%0d_rdata", v), tbl[v].is_ls ? ls_rdata_o : if_rdata_o, tbl[v].exp_rdata);
      chk($sformatf("tbl%0d_idle", v), {mem_req_o, busy_o}, 0);
      @(negedge clk_i); #1;
      chk($sformatf("tbl%0d_pulse", v), {if_rvalid_o, ls_rvalid_o}, 0);
    end

    // simultaneous IF + LS store
    @(negedge clk_i);
    if_req_i = 1; if_addr_i = 32'h300;
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h2000; ls_be_i = 4'b0011; ls_wdata_i = 32'hDEADBEEF;
    #1; chk("sim_ls_first", {if_gnt_o, ls_gnt_o}, 2'b01);
    @(negedge clk_i); ls_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h99999999; #1;
    chk("sim_store_port", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, {1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF});
    chk("sim_if_in_completion", {if_gnt_o, ls_gnt_o}, 2'b10);
    @(negedge clk_i); if_req_i = 0; mem_rdata_i = 32'h0BADF00D; #1;
    chk("sim_ls_rvalid", ls_rvalid_o, 1);
    chk("sim_ls_rdata_kept", ls_rdata_o, 32'h11223344);
    chk("sim_fetch_port", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 1'b0, 4'hF, 32'h300});
    @(negedge clk_i); mem_ready_i = 0; #1;
    chk("sim_if_rvalid", {if_rvalid_o, ls_rvalid_o, if_rdata_o}, {2'b10, 32'h0BADF00D});

    // starvation, zero wait-states
    starve_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    mem_rdata_i = 32'h5A5A0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if_req_i = 1; if_addr_i = 32'h600; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h3000;
      mem_ready_i = (k > 0);
      #1; chk($sformatf("starve_gnt%0d", k), {if_gnt_o, ls_gnt_o}, starve_pat[k] ? 2'b01 : 2'b10);
    end
    @(negedge clk_i); if_req_i = 0; ls_req_i = 0; mem_ready_i = 1;
    @(negedge clk_i); mem_ready_i = 0; #1;
    chk("starve_last_if_rv", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h5A5A0000});

    // flush during BUSY_IF with late ready
    @(negedge clk_i); if_req_i = 1; if_addr_i = 32'h400; #1;
    chk("flush_gnt", if_gnt_o, 1);
    @(negedge clk_i); if_req_i = 0;
    @(negedge clk_i); if_flush_i = 1;
    @(negedge clk_i); if_flush_i = 0; mem_ready_i = 1; mem_rdata_i = 32'hBAD0BAD0; #1;
    chk("flush_mem_completes", {mem_req_o, mem_addr_o}, {1'b1, 32'h400});
    @(negedge clk_i); mem_ready_i = 0; #1;
    chk("flush_no_rvalid", {if_rvalid_o, if_rdata_o}, {1'b0, 32'h5A5A0000});
    if_req_i = 1; if_addr_i = 32'h404; #1;
    chk("flush_next_gnt", if_gnt_o, 1);
    @(negedge clk_i); if_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h600D600D;
    @(negedge clk_i); mem_ready_i = 0; #1;
    chk("flush_next_data", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h600D600D});

    // reset in the middle of a load
    @(negedge clk_i); ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h2000; ls_be_i = 4'hF; #1;
    chk("rstmid_gnt", ls_gnt_o, 1);
    @(negedge clk_i); #1; chk("rstmid_busy", busy_o, 1);
    #2 rst_n_i = 0; #1;
    chk("rstmid_async_ctl", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, busy_o, mem_we_o, mem_be_o}, 0);
    chk("rstmid_async_data", {mem_addr_o, if_rdata_o, ls_rdata_o}, 0);
    @(negedge clk_i); ls_req_i = 0; if_req_i = 1; if_addr_i = 32'h500;
    @(negedge clk_i); rst_n_i = 1; #1;
    chk("rstmid_if_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
    @(negedge clk_i); if_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h12345678; #1;
    chk("rstmid_port", {mem_req_o, mem_addr_o, ls_rvalid_o}, {1'b1, 32'h500, 1'b0});
    @(negedge clk_i); mem_ready_i = 0; #1;
    chk("rstmid_if_rv", {if_rvalid_o, ls_rvalid_o, if_rdata_o}, {2'b10, 32'h12345678});

    // randomized run against the reference model
    @(negedge clk_i); rst_n_i = 0; idle_inputs();
    @(negedge clk_i); rst_n_i = 1;
    m_own = 0; m_we = 0; m_kill = 0; m_if_rv = 0; m_ls_rv = 0; m_be = 0;
    m_addr = 0; m_wdata = 0; m_if_rd = 0; m_ls_rd = 0; m_starve = 0;
    g_if = 0; g_ls = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (g_if || !if_req_i) begin
        if_req_i = ($urandom_range(0, 3) != 0); if_addr_i = $urandom & ~32'h3;
      end else if ($urandom_range(0, 15) == 0) if_req_i = 0;
      if (g_ls || !ls_req_i) begin
        ls_req_i = ($urandom_range(0, 2) != 0); ls_we_i = $urandom_range(0, 1);
        ls_be_i = 4'($urandom_range(0, 15)); ls_addr_i = $urandom; ls_wdata_i = $urandom;
      end else if ($urandom_range(0, 15) == 0) ls_req_i = 0;
      if_flush_i  = ($urandom_range(0, 7) == 0);
      mem_ready_i = (m_own != 0) && ($urandom_range(0, 2) != 0);
      mem_rdata_i = $urandom;
      #1;
      arb  = (m_own == 0) || mem_ready_i;
      e_ls = arb && ls_req_i && !(if_req_i && m_starve == SMAX);
      e_if = arb && if_req_i && !e_ls;
      chk("rnd_gnt", {if_gnt_o, ls_gnt_o}, {e_if, e_ls});
      chk("rnd_req_busy", {mem_req_o, busy_o}, {2{m_own != 0}});
      if (m_own != 0) begin
        chk("rnd_port", {mem_we_o, mem_be_o, mem_addr_o}, {m_we, m_be, m_addr});
        if (m_we) chk("rnd_wdata", mem_wdata_o, m_wdata);
      end
      chk("rnd_if_resp", {if_rvalid_o, if_rdata_o}, {m_if_rv, m_if_rd});
      chk("rnd_ls_resp", {ls_rvalid_o, ls_rdata_o}, {m_ls_rv, m_ls_rd});
      nx_if_rv = 0; nx_ls_rv = 0;
      if (m_own == 1 && mem_ready_i) begin
        if (!(m_kill || if_flush_i)) begin nx_if_rv = 1; m_if_rd = mem_rdata_i; end
        m_kill = 0;
      end else if (m_own == 1 && if_flush_i) m_kill = 1;
      if (m_own == 2 && mem_ready_i) begin
        nx_ls_rv = 1;
        if (!m_we) m_ls_rd = mem_rdata_i;
      end
      if (e_if && if_flush_i) m_kill = 1;
      if (arb) begin
        if (!if_req_i || e_if) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (e_ls) begin
          m_own = 2; m_we = ls_we_i; m_be = ls_be_i; m_addr = ls_addr_i; m_wdata = ls_wdata_i;
        end else if (e_if) begin
          m_own = 1; m_we = 0; m_be = 4'hF; m_addr = if_addr_i;
        end else m_own = 0;
      end
      m_if_rv = nx_if_rv; m_ls_rv = nx_ls_rv;
      g_if = e_if; g_ls = e_ls;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and the load/store unit (LS) of the 5-stage core.
- Arbitrates requests and drives the memory port with a latched request. Waits out memory wait-states, then returns registered responses to the winning requester.
- LS has fixed priority. A starvation counter forces an IF grant after STARVE_MAX consecutive LS wins. IF responses can be squashed by a pipeline flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive LS grants, with IF waiting, before IF is forced; must be >= 1

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high
- if_flush_i  in  1  squash any in-flight or just-granted fetch response
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  DATA_W  fetch data
- ls_req_i  in  1  load/store request; held until ls_gnt_o
- ls_we_i  in  1  1 = store
- ls_be_i  in  DATA_W/8  byte enables
- ls_addr_i  in  ADDR_W  address
- ls_wdata_i  in  DATA_W  store data
- ls_gnt_o  out  1  LS request accepted this cycle
- ls_rvalid_o  out  1  load data valid or store done, one-cycle pulse
- ls_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_rdata_i  in  DATA_W  read data, valid when mem_ready_i is high
- busy_o  out  1  a transaction is outstanding (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values:
  - state = IDLE, starvation counter = 0
  - all outputs = 0, including the rdata registers
  - an in-flight transaction is abandoned; the memory must accept a dropped request
- States:
  - IDLE: no request outstanding.
  - BUSY_IF: request register holds a fetch.
  - BUSY_LS: request register holds a load/store.
- Arbitration point: any IDLE cycle, or a BUSY cycle with mem_ready_i=1 (back-to-back issue).
- Arbitration decision:
  - Only LS requests: grant LS.
  - Only IF requests: grant IF.
  - Both request: grant LS unless starve_cnt == STARVE_MAX, in which case grant IF.
  - No requests: go to IDLE.
- Grant:
  - The gnt_o pulse is combinational, in the arbitration cycle.
  - The payload is latched into the request register; next state is BUSY_IF or BUSY_LS.
  - At most one gnt_o is high per cycle.
- Starvation counter:
  - Increments on an LS grant while if_req_i=1, saturating at STARVE_MAX.
  - Clears on an IF grant, or at any arbitration point where if_req_i=0.
- Memory port in BUSY:
  - mem_req_o=1 with mem_* driven from the request register, stable until mem_ready_i.
  - mem_we_o=0 and mem_be_o=all-ones for fetches.
  - In IDLE, mem_req_o=0 and the other mem_* outputs are don't-care.
- Completion (BUSY with mem_ready_i=1):
  - mem_rdata_i is registered into the owner's rdata register; ls_rdata_o is unchanged for stores.
  - The owner's rvalid_o pulses the following cycle.
  - Minimum latency from grant to rvalid is 2 cycles when mem_ready_i is high the first BUSY cycle.
  - Throughput is one transaction per cycle under zero wait-states.
- Flush:
  - A sticky squash bit sets when if_flush_i=1 during BUSY_IF, or in a cycle where if_gnt_o=1.
  - While set, the in-flight fetch still completes on the memory, but if_rvalid_o is suppressed and if_rdata_o is not updated.
  - The bit clears at that fetch's completion.
  - if_flush_i has no effect in IDLE or BUSY_LS.
- Request contract:
  - A requester may drop req before its grant with no effect.
  - Payload changes after the grant are ignored.
- The memory must not assert mem_ready_i while mem_req_o=0; the arbiter ignores it in IDLE.

Test Plan:
- IF-only fetch: if_req_i=1, if_addr_i=0x100; mem_ready_i=1 from the first BUSY cycle, mem_rdata_i=0x00A00093 -> if_gnt_o at cycle 0, mem_req_o/addr=0x100 at cycle 1, if_rvalid_o=1 with if_rdata_o=0x00A00093 at cycle 2.
- Simultaneous IF+LS: both requesting in IDLE, ls_we_i=1, ls_addr_i=0x2000, ls_be_i=4'b0011, ls_wdata_i=0xDEADBEEF -> ls_gnt_o first, then mem_we_o=1 with be=0011 and wdata=0xDEADBEEF; IF granted in the completion cycle; ls_rvalid_o pulses, ls_rdata_o unchanged.
- Starvation: LS and IF requesting continuously, STARVE_MAX=4, zero wait-states -> grant order LS,LS,LS,LS,IF,LS...; counter=0 after the IF grant.
- Wait-states: LS load, mem_ready_i low for 3 BUSY cycles -> mem_addr_o/mem_req_o stable for 4 cycles, busy_o=1 throughout, ls_rvalid_o exactly once, on the cycle after mem_ready_i.
- Flush: if_flush_i=1 in the second cycle of BUSY_IF (mem_ready_i late) -> the memory access completes, if_rvalid_o stays 0 and if_rdata_o keeps its previous value; the next fetch returns its data normally.
- Reset mid-transaction: assert rst_n_i=0 during BUSY_LS with mem_ready_i low -> all outputs 0 immediately (asynchronously); after release, state IDLE and the next IF request is granted with no stale ls_rvalid_o.
